// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register width, hazard FSM encodings,
// and the hard-wired zero register.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] HZ_IDLE        = 2'd0;
  localparam logic [1:0] HZ_LOAD_BUBBLE = 2'd1;
  localparam logic [1:0] HZ_JUMP_FLUSH  = 2'd2;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_match.sv
// Combinational source/destination comparator producing rs1/rs2 hits.
// Ports: valid/uses/rs in, producer wr_reg/wr_en in, hit1/hit2 out.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         valid,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  input  logic         uses1,
  input  logic         uses2,
  input  logic [W-1:0] wr_reg,
  input  logic         wr_en,
  output logic         hit1,
  output logic         hit2
);

  logic live;

  // Register zero is hard-wired, so a write to it never produces a value.
  assign live = valid && wr_en && (wr_reg != W'(REG_ZERO));
  assign hit1 = live && uses1 && (wr_reg == rs1);
  assign hit2 = live && uses2 && (wr_reg == rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: load-use bubbles, jump flushes, EX fwd.
// Ports: decode operands, ID/EX producer info in; stall/hold/fwd/state out.
// Optional HAZARD_STATS_EN adds stall_count and fwd_count outputs.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RW           = REG_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec_valid,
  input  logic [RW-1:0] dec_rs1,
  input  logic [RW-1:0] dec_rs2,
  input  logic          dec_uses_rs1,
  input  logic          dec_uses_rs2,
  input  logic [RW-1:0] ex_write_reg,
  input  logic          ex_reg_wrenable,
  input  logic          ex_mem_to_reg,
  input  logic          ex_is_jump,
  output logic          should_stall,
  output logic          pc_hold,
  output logic          fwd_a,
  output logic          fwd_b,
  output logic [1:0]    state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stall_count,
  output logic [31:0]   fwd_count
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  logic       hit1;
  logic       hit2;

  hazard_match #(.W(RW)) u_match (
    .valid  (dec_valid),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .uses1  (dec_uses_rs1),
    .uses2  (dec_uses_rs2),
    .wr_reg (ex_write_reg),
    .wr_en  (ex_reg_wrenable),
    .hit1   (hit1),
    .hit2   (hit2)
  );

  always_comb begin
    should_stall = 1'b0;
    pc_hold      = 1'b0;
    fwd_a        = 1'b0;
    fwd_b        = 1'b0;
    state_nx     = state;
    cnt_nx       = cnt;
    unique case (state)
      HZ_JUMP_FLUSH: begin
        should_stall = 1'b1;
        if (cnt != 3'd0) cnt_nx = cnt - 3'd1;
        if (cnt <= 3'd1) state_nx = HZ_IDLE;
      end
      default: begin
        // LOAD_BUBBLE shares IDLE's output rules; the bubble at ID/EX
        // carries no jump or write, so only the forwarding path applies.
        if (ex_is_jump) begin
          should_stall = 1'b1;
          if (state == HZ_IDLE) begin
            cnt_nx   = FLUSH_INIT;
            state_nx = (FLUSH_CYCLES > 1) ? HZ_JUMP_FLUSH : HZ_IDLE;
          end
        end else if (ex_mem_to_reg && (hit1 || hit2)) begin
          should_stall = 1'b1;
          pc_hold      = 1'b1;
          if (state == HZ_IDLE) state_nx = HZ_LOAD_BUBBLE;
        end else begin
          fwd_a = hit1;
          fwd_b = hit2;
        end
        if (state == HZ_LOAD_BUBBLE) state_nx = HZ_IDLE;
      end
    endcase
    if (reset) begin
      should_stall = 1'b0;
      pc_hold      = 1'b0;
      fwd_a        = 1'b0;
      fwd_b        = 1'b0;
      state_nx     = HZ_IDLE;
      cnt_nx       = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nx;
    cnt   <= cnt_nx;
  end

  assign state_o = state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (should_stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if ((fwd_a || fwd_b) && (fwd_count != 32'hFFFF_FFFF))
        fwd_count <= fwd_count + 32'd1;
    end
  end
`endif

endmodule
